cic_3_interpolator: RTL
=======================

CIC_3_INTERPOLATOR -- requirements
Module: cic_3_interpolator

Interface
REQ-001 Parameter R, default 4, meaning: interpolation ratio; SHALL be a power of two, >= 2.
REQ-002 Parameter width, default 16, meaning: input sample width in bits.
REQ-003 Derived OW = width + 2*$clog2(R): output width and the width of every internal arithmetic register.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 clk_in  input  1  clock; output sample rate, R times the input sample rate.
REQ-006 in  input  width  signed two's-complement input sample.
REQ-007 in_valid  input  1  in holds a sample offered for acceptance.
REQ-008 in_ready  output  1  block accepts in this cycle.
REQ-009 out  output  OW  signed interpolated output, one sample per clk_in cycle.
REQ-010 out_valid  output  1  out carries filter output.
REQ-011 underrun  output  1  sticky; an input slot passed without a valid sample.

Function
REQ-012 Accept SHALL occur in a cycle where in_valid && in_ready; with in_ready low, in_valid is ignored, nothing is consumed, and in is held by the source.
REQ-013 The block SHALL have two states, IDLE and RUN; reset enters IDLE.
REQ-014 In IDLE, in_ready SHALL be 1 every cycle; an accept SHALL move the block to RUN and set the phase counter to 1.
REQ-015 In RUN, the phase counter SHALL count 0..R-1 every clk_in cycle, wrapping R-1 -> 0; in_ready SHALL be 1 only at phase 0 (the slot strobe).
REQ-016 The comb section SHALL run once per slot strobe (IDLE accept, or RUN phase 0): x = in if accepted, otherwise 0.
REQ-017 A RUN slot strobe with in_valid low SHALL feed x = 0 and set underrun to 1; underrun SHALL clear only on reset.
REQ-018 Comb section: three cascaded first differences, differential delay 1; y = x - x', etc.; each stage keeps its previous input in a delay register updated only on slot strobes.
REQ-019 The comb result register cr SHALL be loaded with the third difference on the slot strobe edge.
REQ-020 Zero-stuffing: integrator input u SHALL equal cr in the cycle immediately after a slot strobe, and 0 in all other cycles.
REQ-021 Integrator section: three registered accumulators, updated every clk_in cycle: i0 <= i0 + u; i1 <= i1 + i0; i2 <= i2 + i1; out = i2.
REQ-022 All arithmetic SHALL be OW-bit two's-complement with modular wrap-around, no saturation; the final result is exact because DC gain is R^2.
REQ-023 Latency: a sample accepted in cycle t SHALL first affect out in cycle t+4.
REQ-024 Impulse response, R=4: out sequence from t+4 SHALL be 1,3,6,10,12,12,10,6,3,1 times the sample, then 0; general form is a triple length-R boxcar convolution, sum R^3.
REQ-025 out_valid SHALL rise in cycle t+4 after the first accept and stay 1 until reset.
REQ-026 An accept and an underrun cannot coincide; an accept at a strobe SHALL never set underrun.
REQ-027 IDLE cycles SHALL NOT set underrun.

Reset
REQ-028 Reset SHALL drive all of the following to 0: comb delays, cr, integrators, phase counter, out, out_valid and underrun; the state SHALL be IDLE.
REQ-029 in_ready SHALL read 0 while reset is asserted and 1 in the first cycle after deassertion.
REQ-030 Reset asserted mid-RUN SHALL immediately discard all filter state; no partial output SHALL appear after release.

Verification
REQ-031 R=4, width=8: reset, accept in=1 at cycle t, then in=0 at every strobe -> out = 1,3,6,10,12,12,10,6,3,1 on cycles t+4..t+13, then 0; out_valid rises at t+4.
REQ-032 R=4: constant in=5 at every strobe -> out settles to 80 (5*16) after 13 cycles and holds; underrun stays 0.
REQ-033 R=4, width=8: constant in=-128 -> out settles to -2048, with no wrap error visible on out.
REQ-034 RUN, in_valid low at one strobe -> underrun = 1 from the next cycle and sticky; out equals the response to a 0 sample in that slot.
REQ-035 in_valid held high between strobes -> only one accept per R cycles; in_ready pulses 1 of every R cycles.
REQ-036 Reset pulse mid-impulse response -> out, out_valid, underrun = 0 immediately; after release, in_ready = 1 and the block waits in IDLE.

Source files
------------

// File: rtl/cic_3_interpolator_if.sv
// Sample stream bundle for the 3-stage CIC interpolator.
// master: source side (in, in_valid); slave: filter side (in_ready, out, out_valid, underrun).
interface cic_3_interpolator_if #(
    parameter int width = 16,
    parameter int OW    = 20
);
    logic signed [width-1:0] in;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [OW-1:0]    out;
    logic                    out_valid;
    logic                    underrun;

    modport master (
        output in, in_valid,
        input  in_ready, out, out_valid, underrun
    );

    modport slave (
        input  in, in_valid,
        output in_ready, out, out_valid, underrun
    );
endinterface

// File: rtl/cic_3_interpolator.sv
// Three-stage CIC interpolator by R: comb at the input rate, zero-stuff, integrate at clk_in.
// Ports: clk_in, reset (async, active-high), bus (slave): in/in_valid/in_ready, out/out_valid, underrun.
module cic_3_interpolator #(
    parameter int R     = 4,
    parameter int width = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    cic_3_interpolator_if.slave  bus
);
    localparam int PW = $clog2(R);
    localparam int OW = width + 2 * PW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]           state;
    logic [PW-1:0]        phase;
    logic                 in_ready;
    logic                 accept;
    logic                 strobe;
    logic                 strobe_d;
    logic signed [OW-1:0] x;
    logic signed [OW-1:0] d1, d2, d3;
    logic signed [OW-1:0] z1, z2, z3;
    logic signed [OW-1:0] cr;
    logic signed [OW-1:0] u;
    logic signed [OW-1:0] i0, i1, i2;
    logic [2:0]           vpipe;
    logic                 out_valid;
    logic                 underrun;

    // A slot opens every cycle while idle, and at phase 0 once running.
    assign in_ready = !reset && ((state == IDLE) || (phase == '0));
    assign accept   = bus.in_valid && in_ready;
    assign strobe   = (state == IDLE) ? accept : (phase == '0);

    assign x  = accept ? {{(OW-width){bus.in[width-1]}}, bus.in} : '0;
    assign d1 = x  - z1;
    assign d2 = d1 - z2;
    assign d3 = d2 - z3;

    // Zero-stuffing: the comb result enters the integrators for one cycle only.
    assign u = strobe_d ? cr : '0;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            if (state == IDLE) begin
                if (accept) begin
                    state <= RUN;
                    phase <= PW'(1);
                end
            end else begin
                // R is a power of two, so natural wrap gives R-1 -> 0.
                phase <= phase + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            z1       <= '0;
            z2       <= '0;
            z3       <= '0;
            cr       <= '0;
            strobe_d <= 1'b0;
        end else begin
            strobe_d <= strobe;
            if (strobe) begin
                z1 <= x;
                z2 <= d1;
                z3 <= d2;
                cr <= d3;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            i0 <= '0;
            i1 <= '0;
            i2 <= '0;
        end else begin
            i0 <= i0 + u;
            i1 <= i1 + i0;
            i2 <= i2 + i1;
        end
    end

    // Sticky marker travels alongside the first sample: cr, i0, i1, i2.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            vpipe     <= '0;
            out_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            vpipe[0]  <= vpipe[0] | accept;
            vpipe[1]  <= vpipe[0];
            vpipe[2]  <= vpipe[1];
            out_valid <= vpipe[2];
            if ((state == RUN) && (phase == '0) && !bus.in_valid) begin
                underrun <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out       = i2;
    assign bus.out_valid = out_valid;
    assign bus.underrun  = underrun;
endmodule
